// File: rtl/div_seq_if.sv
// rtl/div_seq_if.sv - EX-stage to divider sequencer handshake bundle
interface div_seq_if;
  logic        start_i;
  logic        annul_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  modport master (
    output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/div_seq.sv
// rtl/div_seq.sv - multi-cycle restoring 32-bit divider producing {HI, LO} for DIV/DIVU
module div_seq (
  input  logic       clk,
  input  logic       rst,
  div_seq_if.slave   div
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t      state, state_n;
  logic [5:0]  cnt, cnt_n;
  logic [64:0] wr, wr_n;
  logic [31:0] divisor, divisor_n;
  logic        sgn_mode, sgn_mode_n;
  logic        sign_a, sign_a_n;
  logic        sign_b, sign_b_n;
  logic [63:0] result, result_n;
  logic        ready, ready_n;

  logic [31:0] a_abs, b_abs;
  logic [64:0] shifted;
  logic [32:0] diff;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    a_abs   = (div.signed_div_i && div.opdata1_i[31]) ? -div.opdata1_i : div.opdata1_i;
    b_abs   = (div.signed_div_i && div.opdata2_i[31]) ? -div.opdata2_i : div.opdata2_i;
    shifted = {wr[63:0], 1'b0};
    // Bit 32 of the 33-bit trial difference is set exactly when it went negative.
    diff    = shifted[64:32] - {1'b0, divisor};
    quo_fix = (sgn_mode && (sign_a ^ sign_b)) ? -wr[31:0] : wr[31:0];
    rem_fix = (sgn_mode && sign_a) ? -wr[63:32] : wr[63:32];
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    wr_n       = wr;
    divisor_n  = divisor;
    sgn_mode_n = sgn_mode;
    sign_a_n   = sign_a;
    sign_b_n   = sign_b;
    result_n   = result;
    ready_n    = ready;

    case (state)
      FREE: begin
        if (div.start_i && !div.annul_i) begin
          sgn_mode_n = div.signed_div_i;
          sign_a_n   = div.signed_div_i & div.opdata1_i[31];
          sign_b_n   = div.signed_div_i & div.opdata2_i[31];
          divisor_n  = b_abs;
          wr_n       = {33'd0, a_abs};
          cnt_n      = 6'd0;
          state_n    = (div.opdata2_i == 32'd0) ? BYZERO : ON;
        end
      end
      BYZERO: begin
        result_n = 64'd0;
        state_n  = div.annul_i ? FREE : END;
      end
      ON: begin
        if (div.annul_i) begin
          state_n  = FREE;
          cnt_n    = 6'd0;
          result_n = 64'd0;
          ready_n  = 1'b0;
        end else if (cnt != 6'd32) begin
          if (!diff[32]) wr_n = {diff, shifted[31:1], 1'b1};
          else           wr_n = {shifted[64:1], 1'b0};
          cnt_n = cnt + 6'd1;
        end else begin
          result_n = {rem_fix, quo_fix};
          ready_n  = 1'b1;
          cnt_n    = 6'd0;
          state_n  = END;
        end
      end
      END: begin
        // The divide-by-zero path arrives here with ready low and raises it one edge later.
        if (div.annul_i || !div.start_i) begin
          state_n  = FREE;
          result_n = 64'd0;
          ready_n  = 1'b0;
        end else begin
          ready_n  = 1'b1;
        end
      end
      default: state_n = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= 6'd0;
      wr       <= 65'd0;
      divisor  <= 32'd0;
      sgn_mode <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      result   <= 64'd0;
      ready    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      wr       <= wr_n;
      divisor  <= divisor_n;
      sgn_mode <= sgn_mode_n;
      sign_a   <= sign_a_n;
      sign_b   <= sign_b_n;
      result   <= result_n;
      ready    <= ready_n;
    end
  end

  assign div.result_o   = result;
  assign div.ready_o    = ready;
  assign div.stallreq_o = div.start_i & ~div.annul_i & ~ready;

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - directed self-checking bench for div_seq
module tb_div_seq;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  div_seq_if dif ();

  div_seq dut (
    .clk (clk),
    .rst (rst),
    .div (dif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one division with start held, then release and confirm the clear.
  task automatic run_div(string tag, bit sg, logic [31:0] a, logic [31:0] b,
                         logic [63:0] exp, int exp_lat);
    int n;
    int stall;
    dif.signed_div_i = sg;
    dif.opdata1_i    = a;
    dif.opdata2_i    = b;
    dif.annul_i      = 1'b0;
    dif.start_i      = 1'b1;
    #1;
    stall = dif.stallreq_o ? 1 : 0;
    for (n = 1; n <= 60; n++) begin
      tick();
      if (n == 1) begin
        dif.opdata1_i    = ~a;
        dif.opdata2_i    = 32'h0000_0001;
        dif.signed_div_i = ~sg;
      end
      if (dif.ready_o) break;
      if (dif.stallreq_o) stall++;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " stall cycles"}, 64'(stall), 64'(exp_lat));
    check({tag, " result"}, dif.result_o, exp);
    check({tag, " stall drop"}, 64'(dif.stallreq_o), 64'd0);
    tick();
    check({tag, " hold ready"}, 64'(dif.ready_o), 64'd1);
    check({tag, " hold result"}, dif.result_o, exp);
    dif.start_i = 1'b0;
    tick();
    check({tag, " ready clear"}, 64'(dif.ready_o), 64'd0);
    check({tag, " result clear"}, dif.result_o, 64'd0);
  endtask

  initial begin
    int rose;
    rst              = 1'b1;
    dif.start_i      = 1'b0;
    dif.annul_i      = 1'b0;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd0;
    dif.opdata2_i    = 32'd0;
    tick();
    tick();
    check("reset ready", 64'(dif.ready_o), 64'd0);
    check("reset result", dif.result_o, 64'd0);
    check("reset stall", 64'(dif.stallreq_o), 64'd0);
    rst = 1'b0;
    tick();

    run_div("u100/7",   1'b0, 32'd100,       32'd7,         {32'h0000_0002, 32'h0000_000E}, 34);
    run_div("s-7/2",    1'b1, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);
    run_div("s7/-2",    1'b1, 32'h0000_0007, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 34);
    run_div("s-8/-3",   1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, {32'hFFFF_FFFE, 32'h0000_0002}, 34);
    run_div("u3/10",    1'b0, 32'd3,         32'd10,        {32'h0000_0003, 32'h0000_0000}, 34);
    run_div("u5/0",     1'b0, 32'd5,         32'd0,         64'd0,                          3);
    run_div("s_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 34);
    run_div("u_ovf",    1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000}, 34);

    // Flush mid-division, then issue a fresh request immediately.
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd100;
    dif.opdata2_i    = 32'd7;
    dif.start_i      = 1'b1;
    rose = 0;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (dif.ready_o) rose = 1;
    end
    dif.annul_i = 1'b1;
    #1;
    check("annul stall", 64'(dif.stallreq_o), 64'd0);
    tick();
    if (dif.ready_o) rose = 1;
    check("annul no ready", 64'(rose), 64'd0);
    check("annul result", dif.result_o, 64'd0);
    run_div("u9/3", 1'b0, 32'd9, 32'd3, {32'h0000_0000, 32'h0000_0003}, 34);

    // Reset mid-division clears outputs and returns the FSM to FREE.
    dif.opdata1_i = 32'd100;
    dif.opdata2_i = 32'd7;
    dif.start_i   = 1'b1;
    for (int i = 0; i < 21; i++) tick();
    rst         = 1'b1;
    dif.start_i = 1'b0;
    tick();
    check("rst ready", 64'(dif.ready_o), 64'd0);
    check("rst result", dif.result_o, 64'd0);
    check("rst stall", 64'(dif.stallreq_o), 64'd0);
    rst = 1'b0;
    run_div("post-rst", 1'b0, 32'd100, 32'd7, {32'h0000_0002, 32'h0000_000E}, 34);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
